// File: rtl/div_share_ctrl.sv
// Round-robin controller that time-shares one combinational 16/8 array divider
// between two requesters: holds operands for a settle window, then returns a tagged response.
module div_share_ctrl #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_n,
  input  logic [7:0]  req0_d,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_n,
  input  logic [7:0]  req1_d,
  output logic [15:0] core_n,
  output logic [7:0]  core_d,
  input  logic [7:0]  core_q,
  input  logic [7:0]  core_r,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [7:0]  rsp_q,
  output logic [7:0]  rsp_r,
  output logic        rsp_dbz,
  output logic        rsp_ovf,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             ptr;
  logic             gnt0, gnt1;
  logic             acc_id;
  logic [15:0]      acc_n;
  logic [7:0]       acc_d;
  logic             acc_dbz, acc_ovf;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && (!req1_valid || !ptr)) gnt0 = 1'b1;
      else if (req1_valid)                     gnt1 = 1'b1;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign acc_id     = gnt1;
  assign acc_n      = gnt1 ? req1_n : req0_n;
  assign acc_d      = gnt1 ? req1_d : req0_d;
  assign acc_dbz    = (acc_d == 8'd0);
  // Quotient exceeds 8 bits exactly when the dividend's high byte reaches the divisor.
  assign acc_ovf    = !acc_dbz && (acc_n[15:8] >= acc_d);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ptr       <= 1'b0;
      core_n    <= '0;
      core_d    <= '0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_q     <= '0;
      rsp_r     <= '0;
      rsp_dbz   <= 1'b0;
      rsp_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            core_n  <= acc_n;
            core_d  <= acc_d;
            rsp_id  <= acc_id;
            rsp_dbz <= acc_dbz;
            rsp_ovf <= acc_ovf;
            ptr     <= ~acc_id;
            busy    <= 1'b1;
            if (acc_dbz) begin
              // The array output is meaningless for a zero divisor, so answer immediately.
              rsp_q     <= 8'hFF;
              rsp_r     <= acc_n[7:0];
              rsp_valid <= 1'b1;
              state     <= DONE;
            end else begin
              cnt   <= CNT_W'(SETTLE_CYCLES - 1);
              state <= SETTLE;
            end
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            rsp_q     <= core_q;
            rsp_r     <= core_r;
            rsp_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_share_ctrl.sv
// Bench for div_share_ctrl: random and directed traffic against an arithmetic reference
// model with a scoreboard; the attached divider model gives wrong answers until settled.
module tb_div_share_ctrl;
  localparam int SETTLE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        val[2];
  logic [15:0] n_in[2];
  logic [7:0]  d_in[2];
  logic        req0_ready, req1_ready;
  logic [15:0] core_n;
  logic [7:0]  core_d, core_q, core_r;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_dbz, rsp_ovf, busy;
  logic [7:0]  rsp_q, rsp_r;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div_share_ctrl #(.SETTLE_CYCLES(SETTLE), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(val[0]), .req0_ready(req0_ready), .req0_n(n_in[0]), .req0_d(d_in[0]),
    .req1_valid(val[1]), .req1_ready(req1_ready), .req1_n(n_in[1]), .req1_d(d_in[1]),
    .core_n(core_n), .core_d(core_d), .core_q(core_q), .core_r(core_r),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_dbz(rsp_dbz), .rsp_ovf(rsp_ovf), .busy(busy)
  );

  // Divider array model: exact result once inputs have been stable SETTLE cycles, inverted before.
  logic [23:0] last_in = '0;
  int          age = 0;
  int          stable_now;
  logic [7:0]  q_ex, r_ex;

  always @(posedge clk) begin
    if ({core_n, core_d} != last_in) begin
      last_in <= {core_n, core_d};
      age     <= 1;
    end else if (age < 1000) begin
      age <= age + 1;
    end
  end

  assign stable_now = ({core_n, core_d} == last_in) ? age + 1 : 1;

  always_comb begin
    q_ex = 8'h5A;
    r_ex = 8'hA5;
    if (core_d != 8'd0) begin
      q_ex = 8'(int'(core_n) / int'(core_d));
      r_ex = 8'(int'(core_n) % int'(core_d));
    end
    core_q = (stable_now >= SETTLE) ? q_ex : ~q_ex;
    core_r = (stable_now >= SETTLE) ? r_ex : ~r_ex;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard and monitor
  typedef struct {
    logic       id;
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    logic       ovf;
    int         due;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  logic ptr_m = 1'b0;
  logic win;
  bit   in_flight = 0, seen = 0, expect_idle = 0, rst_d = 0;
  int   acc_cyc = 0;
  int   nn, dd;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      in_flight   = 0;
      seen        = 0;
      expect_idle = 0;
      ptr_m       = 1'b0;
      rst_d       = 1;
    end else begin
      if (rst_d)
        check("reset_outputs", 64'({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_q, rsp_r,
                                    rsp_dbz, rsp_ovf, core_n, core_d, busy}), 64'd0);
      rst_d = 0;
      check("busy", 64'(busy), 64'(in_flight));
      check("ready_exclusive", 64'(req0_ready & req1_ready), 64'd0);
      check("ready_without_valid",
            64'((req0_ready & ~val[0]) | (req1_ready & ~val[1])), 64'd0);
      if (expect_idle && (val[0] || val[1]))
        check("grant_after_rsp", 64'(req0_ready | req1_ready), 64'd1);
      expect_idle = 0;

      if (req0_ready || req1_ready) begin
        win = req1_ready;
        check("grant_choice", 64'(win), 64'((val[0] && val[1]) ? ptr_m : val[1]));
        check("accept_while_busy", 64'(in_flight), 64'd0);
        nn    = win ? int'(n_in[1]) : int'(n_in[0]);
        dd    = win ? int'(d_in[1]) : int'(d_in[0]);
        e.id  = win;
        e.dbz = (dd == 0);
        if (dd == 0) begin
          e.ovf = 1'b0;
          e.q   = 8'hFF;
          e.r   = 8'(nn);
          e.due = cyc + 1;
        end else begin
          e.ovf = (nn / dd) > 255;
          e.q   = 8'(nn / dd);
          e.r   = 8'(nn % dd);
          e.due = cyc + 1 + SETTLE;
        end
        sb.push_back(e);
        ptr_m     = ~win;
        in_flight = 1;
        acc_cyc   = cyc;
      end

      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", 64'(rsp_valid), 64'd0);
        end else begin
          if (!seen) begin
            check("latency", 64'(cyc), 64'(sb[0].due));
            seen = 1;
          end
          check("rsp_id", 64'(rsp_id), 64'(sb[0].id));
          check("rsp_q", 64'(rsp_q), 64'(sb[0].q));
          check("rsp_r", 64'(rsp_r), 64'(sb[0].r));
          check("rsp_dbz_ovf", 64'({rsp_dbz, rsp_ovf}), 64'({sb[0].dbz, sb[0].ovf}));
          if (rsp_ready) begin
            void'(sb.pop_front());
            seen        = 0;
            in_flight   = 0;
            expect_idle = 1;
          end
        end
      end else if (in_flight && (cyc - acc_cyc > 100)) begin
        check("rsp_timeout", 64'(rsp_valid), 64'd1);
        in_flight = 0;
        sb.delete();
      end
    end
  end

  // Stimulus
  bit hs[2];

  task automatic step();
    @(negedge clk);
    hs[0] = val[0] && req0_ready;
    hs[1] = val[1] && req1_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hs(input int id);
    bit got = 0;
    for (int k = 0; k < 50 && !got; k++) begin
      step();
      got = hs[id];
    end
    check("accept_wait", 64'(got), 64'd1);
  endtask

  task automatic issue(input int id, input logic [15:0] n, input logic [7:0] d);
    val[id]  = 1'b1;
    n_in[id] = n;
    d_in[id] = d;
    wait_hs(id);
    val[id] = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 300 && (in_flight || rsp_valid); k++) step();
    check("drain", 64'(in_flight), 64'd0);
  endtask

  initial begin
    rst       = 1'b1;
    rsp_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      val[i]  = 1'b0;
      n_in[i] = '0;
      d_in[i] = '0;
    end
    repeat (3) step();
    rst = 1'b0;
    step();

    // Directed: exact divide, divide-by-zero, quotient overflow
    rsp_ready = 1'b1;
    issue(0, 16'd1000, 8'd7);
    wait_idle();
    issue(1, 16'h00AB, 8'd0);
    wait_idle();
    issue(0, 16'h1234, 8'h10);
    wait_idle();

    // Both requesters continuously valid: grants must alternate
    for (int i = 0; i < 2; i++) begin
      val[i]  = 1'b1;
      n_in[i] = 16'($urandom);
      d_in[i] = 8'($urandom_range(255, 1));
    end
    for (int c = 0; c < 60; c++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        if (hs[i]) begin
          n_in[i] = 16'($urandom);
          d_in[i] = 8'($urandom_range(255, 1));
        end
      end
    end
    val[0] = 1'b0;
    val[1] = 1'b0;
    wait_idle();

    // Back-pressure: response held while another request waits
    rsp_ready = 1'b0;
    issue(0, 16'd4321, 8'd13);
    val[1]  = 1'b1;
    n_in[1] = 16'd999;
    d_in[1] = 8'd3;
    for (int k = 0; k < 20 && !rsp_valid; k++) step();
    repeat (6) step();
    rsp_ready = 1'b1;
    wait_hs(1);
    val[1] = 1'b0;
    wait_idle();

    // Reset while the settle counter is at 2
    issue(0, 16'd5000, 8'd9);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    for (int i = 0; i < 2; i++) begin
      val[i]  = 1'b1;
      n_in[i] = 16'(7000 + i);
      d_in[i] = 8'(11 + i);
    end
    for (int k = 0; k < 40 && (val[0] || val[1]); k++) begin
      step();
      for (int i = 0; i < 2; i++) if (hs[i]) val[i] = 1'b0;
    end
    wait_idle();

    // Random traffic with valid dropping and random back-pressure
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 2; i++) begin
        val[i]  = ($urandom_range(3) != 0);
        n_in[i] = 16'($urandom);
        d_in[i] = ($urandom_range(7) == 0) ? 8'd0 : 8'($urandom);
      end
      rsp_ready = 1'($urandom_range(1));
      step();
    end
    val[0]    = 1'b0;
    val[1]    = 1'b0;
    rsp_ready = 1'b1;
    wait_idle();
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
